// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry ready/valid output buffer.
// Samples mid-bit with a down-counter; flags stop-bit errors and dropped bytes.
module uart_rx #(
    parameter int BaudRate  = 57600,
    parameter int ClockFreq = 100_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       valid_o,
    input  logic       ready_i,
    output logic [7:0] data_o,
    output logic       frame_err_o,
    output logic       overrun_o
);
    localparam int CyclesPerBaud = ClockFreq / BaudRate;
    localparam int HalfBaud      = CyclesPerBaud / 2;
    localparam logic [23:0] BaudLoad = 24'(CyclesPerBaud - 1);
    localparam logic [23:0] HalfLoad = 24'(HalfBaud - 1);

    typedef enum logic [2:0] {Idle, Start, Data, Stop, WaitHigh} state_e;

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        rx_meta_q, rx_s;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        byte_done, stop_err, xfer;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s      <= rx_meta_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= Idle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_err  = 1'b0;
        // Counter only runs while timing a bit; reloads happen on each sample.
        if ((state_q == Start || state_q == Data || state_q == Stop) && cnt_q != '0)
            cnt_d = cnt_q - 24'd1;
        unique case (state_q)
            Idle: if (!rx_s) begin
                state_d = Start;
                cnt_d   = HalfLoad;
            end
            Start: if (cnt_q == '0) begin
                if (!rx_s) begin
                    state_d = Data;
                    cnt_d   = BaudLoad;
                    idx_d   = '0;
                end else begin
                    state_d = Idle;
                end
            end
            Data: if (cnt_q == '0) begin
                shift_d[idx_q] = rx_s;
                idx_d          = idx_q + 3'd1;
                cnt_d          = BaudLoad;
                if (idx_q == 3'd7) state_d = Stop;
            end
            Stop: if (cnt_q == '0) begin
                if (rx_s) begin
                    byte_done = 1'b1;
                    state_d   = Idle;
                end else begin
                    stop_err = 1'b1;
                    state_d  = WaitHigh;
                end
            end
            WaitHigh: if (rx_s) state_d = Idle;
            default: state_d = Idle;
        endcase
    end

    // A transfer in the completing cycle frees the slot for the new byte.
    always_comb begin
        xfer    = valid_q && ready_i;
        valid_d = valid_q && !xfer;
        data_d  = data_q;
        ferr_d  = stop_err;
        ovr_d   = 1'b0;
        if (byte_done) begin
            if (!valid_q || xfer) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are pushed into a byte-level model
// and the bytes handed out over ready/valid are compared in order.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int ClockFreq = 1_000_000;
    localparam int BaudRate  = 100_000;
    localparam int CPB       = ClockFreq / BaudRate;
    localparam int HALF      = CPB / 2;
    // start edge -> stop-bit sample: 2 sync flops, 1 Idle cycle, half bit, 9 full bits
    localparam int DONE_LAT  = 3 + HALF + 9 * CPB;

    logic clk_i = 1'b0, rst_i = 1'b1, rx_i = 1'b1;
    logic ready_i, valid_o, frame_err_o, overrun_o;
    logic [7:0] data_o;
    logic rdy_val = 1'b0, rdy_rand = 1'b0, rdy_rnd = 1'b0;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, ferr_cnt = 0, ovr_cnt = 0, vhi_cnt = 0, vlo_cnt = 0, hold_err = 0;
    int t_rise = 0;
    logic [7:0] got[$];
    logic prev_v = 1'b0, prev_x = 1'b0;
    logic [7:0] prev_d = '0;

    uart_rx #(.BaudRate(BaudRate), .ClockFreq(ClockFreq)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .valid_o(valid_o),
        .ready_i(ready_i), .data_o(data_o), .frame_err_o(frame_err_o),
        .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;
    assign ready_i = rdy_val | (rdy_rand & rdy_rnd);

    always @(posedge clk_i) begin
        cyc     <= cyc + 1;
        rdy_rnd <= 1'($urandom_range(0, 1));
    end

    // Passive monitor: collects transfers, pulses and buffer-hold violations.
    always @(negedge clk_i) begin
        if (valid_o && ready_i) got.push_back(data_o);
        if (frame_err_o) ferr_cnt++;
        if (overrun_o) ovr_cnt++;
        if (valid_o) vhi_cnt++; else vlo_cnt++;
        if (valid_o && !prev_v) t_rise = cyc;
        if (prev_v && !prev_x && valid_o && data_o != prev_d) hold_err++;
        prev_v = valid_o;
        prev_x = valid_o && ready_i;
        prev_d = data_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit good);
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            tick(CPB);
        end
        rx_i = good;
        tick(CPB);
        rx_i = 1'b1;
        if (!good) tick(4);
    endtask

    initial begin
        int gi, f0, o0, v0, l0, c0;
        logic [7:0] exp_q[$];
        int exp_ferr;

        // reset state, checked while rst_i is still high
        tick(3);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_data", 32'(data_o), 0);
        chk("rst_ferr", 32'(frame_err_o), 0);
        chk("rst_ovr", 32'(overrun_o), 0);
        rst_i = 1'b0;
        tick(5);

        // single frame, consumer always ready
        rdy_val = 1'b1; gi = got.size(); v0 = vhi_cnt; c0 = cyc;
        send(8'h5A, 1'b1);
        tick(10);
        chk("5a_count", 32'(got.size() - gi), 1);
        if (got.size() > gi) chk("5a_data", 32'(got[gi]), 32'h5A);
        chk("5a_vcycles", 32'(vhi_cnt - v0), 1);
        chk("5a_latency_ok", 32'((t_rise - c0) >= DONE_LAT - 3 && (t_rise - c0) <= DONE_LAT + 2), 1);
        chk("5a_ferr", 32'(ferr_cnt), 0);
        chk("5a_ovr", 32'(ovr_cnt), 0);

        // short glitch is rejected, following frame still received
        gi = got.size();
        rx_i = 1'b0; tick(3); rx_i = 1'b1; tick(40);
        chk("glitch_none", 32'(got.size() - gi), 0);
        chk("glitch_valid", 32'(valid_o), 0);
        send(8'hA5, 1'b1); tick(10);
        chk("a5_count", 32'(got.size() - gi), 1);
        if (got.size() > gi) chk("a5_data", 32'(got[gi]), 32'hA5);

        // framing error then recovery
        gi = got.size(); f0 = ferr_cnt;
        send(8'h3C, 1'b0); tick(10);
        chk("ferr_pulse", 32'(ferr_cnt - f0), 1);
        chk("ferr_none", 32'(got.size() - gi), 0);
        send(8'hC3, 1'b1); tick(10);
        chk("c3_count", 32'(got.size() - gi), 1);
        if (got.size() > gi) chk("c3_data", 32'(got[gi]), 32'hC3);

        // overrun: consumer stalled across two frames
        rdy_val = 1'b0; gi = got.size(); o0 = ovr_cnt;
        send(8'h11, 1'b1);
        send(8'h22, 1'b1); tick(5);
        chk("ovr_pulse", 32'(ovr_cnt - o0), 1);
        chk("ovr_keep", 32'(data_o), 32'h11);
        chk("ovr_valid", 32'(valid_o), 1);
        rdy_val = 1'b1; tick(1); rdy_val = 1'b0; tick(2);
        chk("ovr_drain", 32'(got.size() - gi), 1);
        if (got.size() > gi) chk("ovr_drain_data", 32'(got[gi]), 32'h11);
        chk("ovr_after_valid", 32'(valid_o), 0);

        // transfer in the very cycle the next byte completes
        gi = got.size(); o0 = ovr_cnt;
        send(8'h11, 1'b1); tick(2);
        l0 = vlo_cnt;
        fork
            send(8'h22, 1'b1);
            begin tick(DONE_LAT - 1); rdy_val = 1'b1; tick(1); rdy_val = 1'b0; end
        join
        tick(3);
        chk("same_xfer", 32'(got.size() - gi), 1);
        if (got.size() > gi) chk("same_xfer_data", 32'(got[gi]), 32'h11);
        chk("same_data", 32'(data_o), 32'h22);
        chk("same_vlow", 32'(vlo_cnt - l0), 0);
        chk("same_ovr", 32'(ovr_cnt - o0), 0);
        rdy_val = 1'b1; tick(1); rdy_val = 1'b0; tick(1);

        // reset in the middle of a frame
        gi = got.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        rx_i = 1'b0; tick(CPB);
        rx_i = 1'b1; tick(5 * CPB);
        rst_i = 1'b1; #1;
        chk("mrst_valid", 32'(valid_o), 0);
        chk("mrst_data", 32'(data_o), 0);
        tick(3); rst_i = 1'b0;
        tick(8 * CPB);
        chk("mrst_none", 32'(got.size() - gi), 0);
        chk("mrst_ferr", 32'(ferr_cnt - f0), 0);
        chk("mrst_ovr", 32'(ovr_cnt - o0), 0);
        rdy_val = 1'b1;
        send(8'h81, 1'b1); tick(10);
        chk("81_count", 32'(got.size() - gi), 1);
        if (got.size() > gi) chk("81_data", 32'(got[gi]), 32'h81);

        // randomized frames, random gaps, random consumer backpressure
        rdy_val = 1'b0; rdy_rand = 1'b1;
        gi = got.size(); f0 = ferr_cnt; o0 = ovr_cnt; exp_ferr = 0;
        for (int k = 0; k < 30; k++) begin
            logic [7:0] b;
            bit good;
            b = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            send(b, good);
            if (good) exp_q.push_back(b); else exp_ferr++;
            tick($urandom_range(0, 12));
        end
        tick(40);
        chk("rnd_count", 32'(got.size() - gi), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && gi + k < got.size(); k++)
            chk($sformatf("rnd_byte%0d", k), 32'(got[gi + k]), 32'(exp_q[k]));
        chk("rnd_ferr", 32'(ferr_cnt - f0), 32'(exp_ferr));
        chk("rnd_ovr", 32'(ovr_cnt - o0), 0);
        chk("hold_stable", 32'(hold_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
